// File: rtl/activation_requant.sv
// Activation + requantization pipeline: activation in stage 1, round/shift/saturate in stage 2.
// Two-deep valid/ready pipeline with full backpressure and a sticky saturation-event counter.
module activation_requant #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ACC_WIDTH-1:0]   pre,
    input  logic [1:0]             mode,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  act,
    input  logic                   sat_clr,
    output logic [15:0]            sat_count
);

    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        signed'((ACC_WIDTH+1)'((1 << (DATA_WIDTH-1)) - 1));
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

    function automatic logic [SHIFT_WIDTH-1:0] clamp_shift(input logic [SHIFT_WIDTH-1:0] s);
        if (32'(s) >= 32'(ACC_WIDTH)) return SHIFT_WIDTH'(ACC_WIDTH - 1);
        return s;
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] activate(
        input logic signed [ACC_WIDTH-1:0] p,
        input logic [1:0]                  m
    );
        case (m)
            2'b00:   return p;
            2'b10:   return p[ACC_WIDTH-1] ? (p >>> 3) : p;
            default: return p[ACC_WIDTH-1] ? '0 : p;
        endcase
    endfunction

    // One extra bit of headroom so the rounding bias can never overflow.
    function automatic logic signed [ACC_WIDTH:0] round_shift(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic [SHIFT_WIDTH-1:0]      s
    );
        logic signed [ACC_WIDTH:0] ext;
        logic signed [ACC_WIDTH:0] bias;
        ext = {a[ACC_WIDTH-1], a};
        if (s == '0) return ext;
        bias = signed'((ACC_WIDTH+1)'(1) << (s - SHIFT_WIDTH'(1)));
        return (ext + bias) >>> s;
    endfunction

    function automatic logic is_sat(input logic signed [ACC_WIDTH:0] r);
        return (r > SAT_MAX) || (r < SAT_MIN);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH:0] r);
        if (r > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
        if (r < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
        return r[DATA_WIDTH-1:0];
    endfunction

    logic                          vld_p1_q, vld_p1_d;
    logic signed [ACC_WIDTH-1:0]   a_p1_q, a_p1_d;
    logic [SHIFT_WIDTH-1:0]        shift_p1_q, shift_p1_d;
    logic                          vld_p2_q, vld_p2_d;
    logic signed [DATA_WIDTH-1:0]  act_p2_q, act_p2_d;
    logic [15:0]                   sat_count_q, sat_count_d;

    logic                          adv2, in_fire, load2, sat_p1;
    logic signed [ACC_WIDTH:0]     r_p1;

    assign adv2     = !vld_p2_q || out_ready;
    assign in_ready = !vld_p1_q || adv2;
    assign in_fire  = in_valid && in_ready;
    assign load2    = adv2 && vld_p1_q;

    // Stage 0 -> 1: activation on the accepted sample
    assign a_p1_d     = activate(signed'(pre), mode);
    assign shift_p1_d = clamp_shift(shift);

    // Stage 1 -> 2: round, shift, saturate
    assign r_p1   = round_shift(a_p1_q, shift_p1_q);
    assign sat_p1 = is_sat(r_p1);

    always_comb begin
        vld_p1_d    = vld_p1_q;
        vld_p2_d    = vld_p2_q;
        act_p2_d    = act_p2_q;
        sat_count_d = sat_count_q;
        if (in_fire)   vld_p1_d = 1'b1;
        else if (load2) vld_p1_d = 1'b0;
        if (adv2)      vld_p2_d = vld_p1_q;
        if (load2)     act_p2_d = saturate(r_p1);
        if (sat_clr)
            sat_count_d = '0;
        else if (load2 && sat_p1 && sat_count_q != 16'hFFFF)
            sat_count_d = sat_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            act_p2_q    <= '0;
            sat_count_q <= '0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            act_p2_q    <= act_p2_d;
            sat_count_q <= sat_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            a_p1_q     <= a_p1_d;
            shift_p1_q <= shift_p1_d;
        end
    end

    assign out_valid = vld_p2_q;
    assign act       = act_p2_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_activation_requant.sv
// Randomized + directed bench for activation_requant against an arithmetic reference model.
module tb_activation_requant;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pre_s;
    logic [1:0]  mode_s;
    logic [4:0]  shift_s;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  act;
    logic        sat_clr;
    logic [15:0] sat_count;

    activation_requant #(.DATA_WIDTH(8), .ACC_WIDTH(32), .SHIFT_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .pre(pre_s), .mode(mode_s), .shift(shift_s),
        .out_valid(out_valid), .out_ready(out_ready), .act(act),
        .sat_clr(sat_clr), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct { longint v; bit s; } exp_t;
    exp_t   q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    longint sat_model = 0;
    longint last_act = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint fdiv(input longint n, input longint k);
        return (n >= 0) ? n / k : -((-n + k - 1) / k);
    endfunction

    function automatic longint ref_act(input longint p, input int m, input int s, output bit sat);
        longint a, r;
        int sh;
        sh = (s >= 32) ? 31 : s;
        if (m == 0)      a = p;
        else if (m == 2) a = (p < 0) ? fdiv(p, 8) : p;
        else             a = (p < 0) ? 0 : p;
        r = (sh > 0) ? fdiv(a + (longint'(1) << (sh - 1)), longint'(1) << sh) : a;
        sat = (r > 127) || (r < -128);
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    // Sample handshakes just after the edge, then advance one clock.
    task automatic cycle(output bit acc);
        exp_t e;
        acc = 1'b0;
        #1;
        if (!rst) begin
            if (in_valid && in_ready) begin
                acc = 1'b1;
                e.v = ref_act(longint'($signed(pre_s)), int'(mode_s), int'(shift_s), e.s);
                q.push_back(e);
            end
            if (out_valid && out_ready) begin
                chk("out_has_ref", longint'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("act_vs_model", longint'($signed(act)), e.v);
                    last_act = longint'($signed(act));
                    if (e.s && sat_model < 65535) sat_model++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input longint p, input int m, input int s);
        bit acc;
        int n;
        in_valid = 1'b1;
        pre_s    = 32'(p);
        mode_s   = 2'(m);
        shift_s  = 5'(s);
        n = 0;
        do begin
            cycle(acc);
            n++;
        end while (!acc && n < 50);
        in_valid = 1'b0;
        chk("accept", longint'(acc), 1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        out_ready = 1'b1;
        n = 0;
        while ((q.size() > 0 || out_valid) && n < 50) begin
            cycle(acc);
            n++;
        end
        chk("drain_empty", longint'(q.size()), 0);
    endtask

    task automatic run_one(input string tag, input longint p, input int m, input int s, input longint expc);
        out_ready = 1'b1;
        send(p, m, s);
        drain();
        chk(tag, last_act, expc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        int idx;
        longint items[4] = '{1, 2, 3, 4};

        rst = 1'b1; in_valid = 1'b0; pre_s = '0; mode_s = '0; shift_s = '0;
        out_ready = 1'b0; sat_clr = 1'b0;
        #3;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_act", longint'($signed(act)), 0);
        chk("rst_sat_count", longint'(sat_count), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("post_rst_in_ready", longint'(in_ready), 1);

        // Latency: accept in cycle 0, result visible in cycle 2
        out_ready = 1'b1;
        in_valid = 1'b1; pre_s = 32'd100; mode_s = 2'b00; shift_s = 5'd0;
        cycle(acc);
        in_valid = 1'b0;
        chk("lat_accept", longint'(acc), 1);
        chk("lat_c1_valid", longint'(out_valid), 0);
        cycle(acc);
        chk("lat_c2_valid", longint'(out_valid), 1);
        chk("lat_c2_act", longint'($signed(act)), 100);
        drain();

        run_one("relu_neg",     -50, 1, 0, 0);
        run_one("ident_neg",    -50, 0, 0, -50);
        run_one("leaky_neg",    -50, 2, 0, -7);
        run_one("mode11_neg",   -50, 3, 0, 0);
        run_one("leaky_pos",     40, 2, 0, 40);
        run_one("rnd_300",      300, 0, 2, 75);
        run_one("rnd_6",          6, 0, 2, 2);
        run_one("rnd_m6",        -6, 0, 2, -1);
        run_one("rnd_5",          5, 0, 2, 1);
        run_one("rnd_max_s31", 64'h7FFF_FFFF, 0, 31, 1);

        run_one("sat_pos", 1000, 0, 0, 127);
        chk("sat_count_1", longint'(sat_count), 1);
        run_one("sat_neg", -1000, 0, 0, -128);
        chk("sat_count_2", longint'(sat_count), 2);
        sat_clr = 1'b1;
        cycle(acc);
        sat_clr = 1'b0;
        sat_model = 0;
        chk("sat_clr", longint'(sat_count), 0);

        // Backpressure: consumer stalled for 6 cycles
        out_ready = 1'b0; idx = 0; mode_s = 2'b00; shift_s = 5'd0;
        for (int k = 0; k < 6; k++) begin
            in_valid = (idx < 4);
            pre_s = 32'(items[idx < 4 ? idx : 3]);
            cycle(acc);
            if (acc) idx++;
            if (out_valid) chk("bp_act_hold", longint'($signed(act)), 1);
        end
        chk("bp_accepted", longint'(idx), 2);
        chk("bp_in_ready", longint'(in_ready), 0);
        chk("bp_out_valid", longint'(out_valid), 1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = (idx < 4);
            pre_s = 32'(items[idx < 4 ? idx : 3]);
            chk("bp_nogap", longint'(out_valid), 1);
            cycle(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_last_act", last_act, 4);
        drain();

        // Reset with two results in flight
        out_ready = 1'b0;
        send(1000, 0, 0);
        send(5, 0, 0);
        chk("rst_mid_sat_pre", longint'(sat_count), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", longint'(out_valid), 0);
        chk("rst_mid_act", longint'($signed(act)), 0);
        chk("rst_mid_sat_count", longint'(sat_count), 0);
        chk("rst_mid_in_ready", longint'(in_ready), 1);
        q.delete();
        sat_model = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; pre_s = 32'd9; mode_s = 2'b00; shift_s = 5'd0;
        cycle(acc);
        in_valid = 1'b0;
        chk("rst_new_accept", longint'(acc), 1);
        cycle(acc);
        chk("rst_new_valid", longint'(out_valid), 1);
        chk("rst_new_act", longint'($signed(act)), 9);
        drain();

        // Randomized traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom % 10) < 7;
            out_ready = ($urandom % 10) < 7;
            case ($urandom % 3)
                0:       pre_s = 32'($signed($urandom_range(0, 4000)) - 2000);
                1:       pre_s = 32'($signed($urandom_range(0, 2097152)) - 1048576);
                default: pre_s = $urandom;
            endcase
            mode_s  = 2'($urandom % 4);
            shift_s = 5'($urandom % 32);
            cycle(acc);
        end
        in_valid = 1'b0;
        drain();
        chk("rand_sat_count", longint'(sat_count), sat_model);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
